// File: rtl/uart_frame_rx_if.sv
// Word stream from the frame parser to the network-loading logic.
interface uart_frame_rx_if #(
    parameter int unsigned WORD_BYTES = 2
);
    logic [8*WORD_BYTES-1:0] word;
    logic                    word_valid;
    logic                    word_ready;

    modport master (output word, output word_valid, input word_ready);
    modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/uart_frame_rx.sv
// UART frame parser: acks receiver bytes, checks [HEADER][LEN][payload][CHK]
// frames and emits the payload as little-endian words on a valid/ready stream.
module uart_frame_rx #(
    parameter int unsigned WORD_BYTES     = 2,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_new_value,
    input  logic            rx_error,
    output logic            rx_clear,
    uart_frame_rx_if.master word_if,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code,
    output logic            busy
);
    localparam int unsigned TO_W  = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_PAYLOAD, S_WORD_OUT, S_CHECK, S_DONE, S_ERR
    } state_e;

    state_e                          state_q, state_d;
    logic [WORD_BYTES-1:0][7:0]      buf_q, buf_d;
    logic [7:0]                      chk_q, chk_d;
    logic [CNT_W-1:0]                n_q, n_d;
    logic [CNT_W-1:0]                word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]                byte_idx_q, byte_idx_d;
    logic [TO_W-1:0]                 to_q, to_d;
    logic                            rx_clear_q, rx_clear_d;
    logic                            word_valid_q, word_valid_d;
    logic                            frame_ok_q, frame_ok_d;
    logic                            frame_err_q, frame_err_d;
    logic [1:0]                      err_code_q, err_code_d;
    logic                            busy_q, busy_d;

    logic rx_live_c, in_frame_c, err_ack_c, take_c, timeout_c, hs_c, last_byte_c, last_word_c;

    // Qualified receiver events; a pending error wins over a pending byte.
    assign rx_live_c   = (state_q == S_IDLE) || (state_q == S_LEN) ||
                         (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign in_frame_c  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign err_ack_c   = rx_error && !rx_clear_q && (rx_live_c || (state_q == S_WORD_OUT));
    assign take_c      = rx_new_value && !rx_clear_q && rx_live_c && !err_ack_c;
    assign timeout_c   = in_frame_c && !take_c && !err_ack_c &&
                         (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign hs_c        = (state_q == S_WORD_OUT) && word_if.word_ready;
    assign last_byte_c = (byte_idx_q == IDX_W'(WORD_BYTES - 1));
    assign last_word_c = (CNT_W'(word_cnt_q + CNT_W'(1)) == n_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_c && (rx_data == HEADER)) state_d = S_LEN;
            end
            S_LEN: begin
                if (err_ack_c)      state_d = S_ERR;
                else if (take_c)    state_d = (rx_data == 8'd0) ? S_ERR : S_PAYLOAD;
                else if (timeout_c) state_d = S_ERR;
            end
            S_PAYLOAD: begin
                if (err_ack_c)                   state_d = S_ERR;
                else if (take_c && last_byte_c)  state_d = S_WORD_OUT;
                else if (timeout_c)              state_d = S_ERR;
            end
            S_WORD_OUT: begin
                if (err_ack_c) state_d = S_ERR;
                else if (hs_c) state_d = last_word_c ? S_CHECK : S_PAYLOAD;
            end
            S_CHECK: begin
                if (err_ack_c)      state_d = S_ERR;
                else if (take_c)    state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
                else if (timeout_c) state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        buf_d        = buf_q;
        chk_d        = chk_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        to_d         = '0;
        rx_clear_d   = take_c || err_ack_c;
        word_valid_d = (state_d == S_WORD_OUT);
        frame_ok_d   = (state_d == S_DONE);
        frame_err_d  = (state_d == S_ERR);
        busy_d       = (state_d != S_IDLE);
        err_code_d   = err_code_q;

        if (state_d == S_ERR) begin
            err_code_d = err_ack_c ? 2'd1 : (timeout_c ? 2'd2 : 2'd3);
        end

        // Inter-byte timer runs only while waiting for frame bytes.
        if (in_frame_c)                 to_d = take_c ? '0 : TO_W'(to_q + TO_W'(1));
        else if (state_q == S_WORD_OUT) to_d = to_q;

        if (take_c && (state_q == S_LEN)) begin
            n_d        = rx_data;
            chk_d      = rx_data;
            byte_idx_d = '0;
            word_cnt_d = '0;
        end

        if (take_c && (state_q == S_PAYLOAD)) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (byte_idx_q == IDX_W'(i)) buf_d[i] = rx_data;
            end
            chk_d      = chk_q + rx_data;
            byte_idx_d = byte_idx_q + IDX_W'(1);
        end

        if (hs_c && !err_ack_c) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            byte_idx_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q        <= '0;
            chk_q        <= '0;
            n_q          <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            to_q         <= '0;
            rx_clear_q   <= 1'b0;
            word_valid_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'd0;
            busy_q       <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            chk_q        <= chk_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            to_q         <= to_d;
            rx_clear_q   <= rx_clear_d;
            word_valid_q <= word_valid_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_clear           = rx_clear_q;
    assign word_if.word       = buf_q;
    assign word_if.word_valid = word_valid_q;
    assign frame_ok           = frame_ok_q;
    assign frame_err          = frame_err_q;
    assign err_code           = err_code_q;
    assign busy               = busy_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: frame table plus backpressure, timeout, error and reset sequences.
module tb_uart_frame_rx;
    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_new_value;
    logic       rx_error;
    logic       rx_clear;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_frame_rx_if #(.WORD_BYTES(2)) wif ();

    uart_frame_rx #(.WORD_BYTES(2), .HEADER(8'hA5), .TIMEOUT_CYCLES(20000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_new_value (rx_new_value),
        .rx_error     (rx_error),
        .rx_clear     (rx_clear),
        .word_if      (wif),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor: words accepted and frame pulses, sampled on the falling edge.
    logic [15:0] mon_w [64];
    int          mon_n   = 0;
    int          ok_cnt  = 0;
    int          err_cnt = 0;
    always @(negedge clk) begin
        if (wif.word_valid && wif.word_ready && mon_n < 64) begin
            mon_w[mon_n] = wif.word;
            mon_n = mon_n + 1;
        end
        if (frame_ok)  ok_cnt  = ok_cnt + 1;
        if (frame_err) err_cnt = err_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0]  nb;     // bytes to send
        logic [79:0] bytes;  // first byte in [79:72]
        logic [1:0]  nw;     // words expected
        logic [47:0] words;  // first word in [47:32]
        logic        ok;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_clear(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rx_clear && n < budget);
        check("rx_clear_ack", 32'(rx_clear), 32'd1);
        rx_new_value = 1'b0;
        rx_error     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_new_value = 1'b1;
        wait_clear(200);
    endtask

    task automatic send_err();
        rx_error = 1'b1;
        wait_clear(200);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int          w0, o0, e0;
        logic [79:0] bs;
        logic [47:0] ws;
        w0 = mon_n; o0 = ok_cnt; e0 = err_cnt;
        for (int i = 0; i < int'(v.nb); i++) begin
            bs = v.bytes << (8 * i);
            send_byte(bs[79:72]);
        end
        cyc(10);
        check($sformatf("v%0d_nwords", idx), 32'(mon_n - w0), 32'(v.nw));
        for (int i = 0; i < int'(v.nw); i++) begin
            ws = v.words << (16 * i);
            check($sformatf("v%0d_word%0d", idx, i), 32'(mon_w[w0 + i]), 32'(ws[47:32]));
        end
        check($sformatf("v%0d_frame_ok", idx),  32'(ok_cnt - o0),  32'(v.ok));
        check($sformatf("v%0d_frame_err", idx), 32'(err_cnt - e0), 32'(v.err));
        check($sformatf("v%0d_err_code", idx),  32'(err_code),     32'(v.code));
        check($sformatf("v%0d_busy", idx),      32'(busy),         32'd0);
    endtask

    vec_t vt [7];

    initial begin
        int w0, o0, e0, bad, n;

        // Frame table: checksum = LEN + sum(payload) mod 256.
        vt[0] = '{nb: 4'd7, bytes: {8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16, 24'h0},
                  nw: 2'd2, words: {16'h1234, 16'h5678, 16'h0}, ok: 1'b1, err: 1'b0, code: 2'd0};
        vt[1] = '{nb: 4'd7, bytes: {8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 24'h0},
                  nw: 2'd2, words: {16'h1234, 16'h5678, 16'h0}, ok: 1'b0, err: 1'b1, code: 2'd3};
        vt[2] = '{nb: 4'd4, bytes: {8'h11, 8'h22, 8'hA5, 8'h00, 48'h0},
                  nw: 2'd0, words: 48'h0, ok: 1'b0, err: 1'b1, code: 2'd3};
        vt[3] = '{nb: 4'd5, bytes: {8'hA5, 8'h01, 8'hFF, 8'hEE, 8'hEE, 40'h0},
                  nw: 2'd1, words: {16'hEEFF, 32'h0}, ok: 1'b1, err: 1'b0, code: 2'd3};
        vt[4] = '{nb: 4'd9, bytes: {8'hA5, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'h0},
                  nw: 2'd3, words: {16'hFFFF, 16'hFFFF, 16'hFFFF}, ok: 1'b1, err: 1'b0, code: 2'd3};
        vt[5] = '{nb: 4'd5, bytes: {8'hA5, 8'h01, 8'h00, 8'h80, 8'h82, 40'h0},
                  nw: 2'd1, words: {16'h8000, 32'h0}, ok: 1'b0, err: 1'b1, code: 2'd3};
        vt[6] = '{nb: 4'd7, bytes: {8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16, 24'h0},
                  nw: 2'd2, words: {16'h1234, 16'h5678, 16'h0}, ok: 1'b1, err: 1'b0, code: 2'd1};

        rst_n          = 1'b0;
        rx_data        = 8'h00;
        rx_new_value   = 1'b0;
        rx_error       = 1'b0;
        wif.word_ready = 1'b1;
        cyc(3);
        check("rst_rx_clear",   32'(rx_clear),       32'd0);
        check("rst_word_valid", 32'(wif.word_valid), 32'd0);
        check("rst_word",       32'(wif.word),       32'd0);
        check("rst_frame_ok",   32'(frame_ok),       32'd0);
        check("rst_frame_err",  32'(frame_err),      32'd0);
        check("rst_err_code",   32'(err_code),       32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        rst_n = 1'b1;
        cyc(2);

        for (int i = 0; i < 6; i++) apply_vec(i, vt[i]);

        // rx_error while idle: acked, no abort, code held.
        e0 = err_cnt;
        send_err();
        cyc(5);
        check("idle_err_no_abort", 32'(err_cnt - e0), 32'd0);
        check("idle_err_code",     32'(err_code),     32'd3);
        check("idle_err_busy",     32'(busy),         32'd0);

        // Inter-byte timeout inside a frame.
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h34);
        cyc(19000);
        check("to_not_early", 32'(err_cnt - e0), 32'd0);
        check("to_busy_wait", 32'(busy),         32'd1);
        n = 0;
        while (err_cnt == e0 && n < 3000) begin
            cyc(1);
            n++;
        end
        cyc(3);
        check("to_frame_err", 32'(err_cnt - e0), 32'd1);
        check("to_err_code",  32'(err_code),     32'd2);
        check("to_busy_after", 32'(busy),        32'd0);

        // rx_error after header aborts with code 1, then a clean frame.
        e0 = err_cnt;
        send_byte(8'hA5);
        send_err();
        cyc(4);
        check("rxerr_frame_err", 32'(err_cnt - e0), 32'd1);
        check("rxerr_err_code",  32'(err_code),     32'd1);
        apply_vec(6, vt[6]);

        // Long backpressure on the first word; a byte pends meanwhile.
        w0 = mon_n; o0 = ok_cnt; e0 = err_cnt;
        wif.word_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        n = 0;
        while (!wif.word_valid && n < 50) begin
            cyc(1);
            n++;
        end
        check("bp_valid", 32'(wif.word_valid), 32'd1);
        check("bp_word",  32'(wif.word),       32'h1234);
        rx_data      = 8'h78;
        rx_new_value = 1'b1;
        bad = 0;
        for (int i = 0; i < 50000; i++) begin
            cyc(1);
            if (!wif.word_valid || wif.word !== 16'h1234 || frame_err || rx_clear) bad++;
        end
        check("bp_stable_cycles_bad", 32'(bad),           32'd0);
        check("bp_no_timeout",        32'(err_cnt - e0),  32'd0);
        check("bp_busy",              32'(busy),          32'd1);
        wif.word_ready = 1'b1;
        wait_clear(200);
        send_byte(8'h56);
        send_byte(8'h16);
        cyc(10);
        check("bp_nwords",   32'(mon_n - w0),   32'd2);
        check("bp_word0",    32'(mon_w[w0]),    32'h1234);
        check("bp_word1",    32'(mon_w[w0 + 1]), 32'h5678);
        check("bp_frame_ok", 32'(ok_cnt - o0),  32'd1);
        check("bp_err_code", 32'(err_code),     32'd1);

        // Reset while a word is waiting.
        e0 = err_cnt;
        wif.word_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cyc(2);
        check("mid_rst_valid_before", 32'(wif.word_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", 32'(wif.word_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),           32'd0);
        check("mid_rst_code",  32'(err_code),       32'd0);
        cyc(3);
        rst_n          = 1'b1;
        wif.word_ready = 1'b1;
        cyc(5);
        check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
